// File: rtl/led_matrix_scanner.sv
// Row-multiplexed bicolour LED matrix scanner with whole-frame snapshot and inter-row blanking.
// Optional per-row PWM dimming via the SCAN_PWM_EN macro (adds the brightness input).
module led_matrix_scanner #(
    parameter int DWELL_CYCLES = 256,
    parameter int BLANK_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
`ifdef SCAN_PWM_EN
    input  logic [3:0]        brightness,
`endif
    input  logic [15:0][15:0] RedPixels,
    input  logic [15:0][15:0] GrnPixels,
    output logic [15:0]       row_sel_n,
    output logic [15:0]       red_col,
    output logic [15:0]       grn_col,
    output logic [3:0]        row_idx,
    output logic              frame_start
);

    localparam int MAXC  = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    // At least 4 bits so the PWM phase dwell_cnt[3:0] always exists.
    localparam int CNT_W = ($clog2(MAXC) > 4) ? $clog2(MAXC) : 4;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         row_d;
    logic               capture;
    logic [15:0]        row_sel_d, red_d, grn_d;
    logic [15:0][15:0]  shadow_red, shadow_grn;

`ifdef SCAN_PWM_EN
    function automatic logic [15:0] pwm_gate(input logic [15:0] cols,
                                             input logic [3:0]  phase,
                                             input logic [3:0]  level);
        return (level == 4'd15 || phase < level) ? cols : 16'h0000;
    endfunction
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_idx;
        capture   = 1'b0;
        row_sel_d = 16'hFFFF;
        red_d     = 16'h0000;
        grn_d     = 16'h0000;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    capture = 1'b1;
                    row_d   = 4'd0;
                    cnt_d   = '0;
                    state_d = BLANK;
                end
            end
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    state_d = DRIVE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRIVE: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    if (row_idx != 4'd15) begin
                        row_d   = row_idx + 4'd1;
                        state_d = BLANK;
                    end else if (enable) begin
                        capture = 1'b1;
                        row_d   = 4'd0;
                        state_d = BLANK;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they line up with state_q.
        if (state_d == DRIVE) begin
            row_sel_d = ~(16'h0001 << row_d);
`ifdef SCAN_PWM_EN
            red_d = pwm_gate(shadow_red[row_d], cnt_d[3:0], brightness);
            grn_d = pwm_gate(shadow_grn[row_d], cnt_d[3:0], brightness);
`else
            red_d = shadow_red[row_d];
            grn_d = shadow_grn[row_d];
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            row_idx     <= 4'd0;
            frame_start <= 1'b0;
            row_sel_n   <= 16'hFFFF;
            red_col     <= 16'h0000;
            grn_col     <= 16'h0000;
            shadow_red  <= '0;
            shadow_grn  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_idx     <= row_d;
            frame_start <= capture;
            row_sel_n   <= row_sel_d;
            red_col     <= red_d;
            grn_col     <= grn_d;
            if (capture) begin
                shadow_red <= RedPixels;
                shadow_grn <= GrnPixels;
            end
        end
    end

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
Consumer end of the playfield pixel interface. Takes the 16x16 RedPixels/GrnPixels arrays produced by the playfield logic and drives a row-multiplexed bicolour LED matrix. It snapshots a full frame at each frame boundary, so the display never tears. It then scans rows 0..15 one at a time, with a blanking gap between rows to suppress ghosting.

Parameters:
DWELL_CYCLES, 256, clocks each row is driven; must be >=1 and a multiple of 16.
BLANK_CYCLES, 4, clocks of all-off blanking before each row; must be >=1.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  level; 1 = scan frames, 0 = stop at the next frame boundary
RedPixels  input  [15:0][15:0]  red frame; RedPixels[r][c] = row r, column c
GrnPixels  input  [15:0][15:0]  green frame, same indexing
row_sel_n  output  16  one-hot active-low row select; all ones = no row
red_col  output  16  red column drive for the selected row, active-high
grn_col  output  16  green column drive for the selected row, active-high
row_idx  output  4  index of the row currently being blanked or driven
frame_start  output  1  one-cycle pulse marking a new frame snapshot

Behaviour:
- Fixed: one clock `clk`; `reset` is asynchronous and active-high.
- All outputs are registered and change only on clk edges, or immediately on reset assertion.
- Reset values: state IDLE, row_sel_n=16'hFFFF, red_col=0, grn_col=0, row_idx=0, frame_start=0, shadow frames=0, counters=0.
- States: IDLE, BLANK, DRIVE.
- IDLE:
  - Outputs off.
  - If enable=1 at an edge: capture RedPixels and GrnPixels into shadow registers, set row_idx=0, go to BLANK.
  - frame_start=1 for exactly the cycle following the capture edge.
- BLANK:
  - row_sel_n=all ones, red_col=grn_col=0 for exactly BLANK_CYCLES cycles, then DRIVE.
- DRIVE:
  - row_sel_n[row_idx]=0, all other bits 1.
  - red_col=shadow_red[row_idx], grn_col=shadow_grn[row_idx].
  - Held for exactly DWELL_CYCLES cycles.
- End of DRIVE, row_idx<15: row_idx+1, go to BLANK.
- End of DRIVE, row_idx==15 and enable=1: re-capture both arrays, row_idx=0 (wrap), pulse frame_start, go to BLANK.
- End of DRIVE, row_idx==15 and enable=0: go to IDLE, outputs off.
- Input arrays are sampled only at capture edges. Changes mid-frame are invisible until the next capture.
- enable deasserted mid-frame: the current frame completes through row 15, then IDLE. enable re-asserted before that edge: scanning continues seamlessly.
- Frame period with enable held high: 16*(BLANK_CYCLES+DWELL_CYCLES) clocks; 4160 with defaults. frame_start pulses are spaced by exactly this amount.
- Never more than one row_sel_n bit low. Columns are zero whenever no row is selected.
- Pixel lit in both arrays: red_col and grn_col both driven (yellow). No priority between colours.
- Reset asserted in any state: immediate return to reset values. The scan restarts from IDLE after release.

Optional Feature:
Macro SCAN_PWM_EN.
- When defined:
  - Extra input port brightness [3:0].
  - In DRIVE, red_col/grn_col are gated to zero unless dwell_cnt[3:0] < brightness, where dwell_cnt counts 0..DWELL_CYCLES-1 within the row.
  - brightness=15 forces columns on for the full dwell; brightness=0 keeps columns always off.
  - row_sel_n timing is unchanged; brightness is sampled every cycle.
- When undefined: the brightness port is absent and columns are driven for the full dwell.

Test Plan:
All scenarios use DWELL_CYCLES=4, BLANK_CYCLES=2 unless stated.
1. Reset: hold reset with random inputs -> row_sel_n=FFFF, red_col=grn_col=0, row_idx=0, frame_start=0. Assert reset asynchronously mid-DRIVE -> same values before the next edge.
2. Single pixel: RedPixels[6][9]=1, all else 0, enable=1 -> frame_start 1 cycle later. row 6 DRIVE shows row_sel_n=16'hFFBF, red_col=16'h0200, grn_col=0 for exactly 4 cycles. Every other row shows zero columns.
3. Scan timing: enable held high for 3 frames -> frame_start pulses exactly 96 clocks apart. row_idx sequence is 0..15 then wraps to 0. Each DRIVE is preceded by exactly 2 all-off cycles.
4. Snapshot coherence: during row 3 of frame N, change GrnPixels[10] to 16'h00FF -> row 10 of frame N shows the old value; frame N+1 shows grn_col=16'h00FF.
5. Enable drop: deassert enable during row 5 -> rows 6..15 still scanned, then IDLE with outputs off and no further frame_start. Re-assert -> new capture and frame_start.
6. SCAN_PWM_EN, DWELL_CYCLES=16, brightness=4, all pixels red -> red_col=FFFF for 4 of 16 DRIVE cycles per row. brightness=15 -> 16 of 16. brightness=0 -> 0 of 16.
